ahb_param_arbiter: RTL



---
 rtl/ahb_param_arb_pkg.sv | 32 +++
 rtl/ahb_rr_pick.sv | 36 +++
 rtl/ahb_param_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/ahb_param_arb_pkg.sv
// rtl/ahb_param_arb_pkg.sv - AHB transfer/burst encodings and burst length helper
package ahb_param_arb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  // Remaining SEQ beats after the NONSEQ of a burst; undefined-length bursts report 0.
  function automatic logic [3:0] burst_beats(input hburst_e burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
      default:                      burst_beats = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// rtl/ahb_rr_pick.sv - rotating-priority / fixed-priority requester picker
module ahb_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  input  logic         mode,
  output logic [W-1:0] winner,
  output logic         valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    if (!mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          winner = W'(i);
          valid  = 1'b1;
        end
      end
    end else begin
      // Descending scan so the nearest index after base wins; base itself is checked last.
      for (int k = N; k >= 1; k--) begin
        int idx;
        idx = (int'(base) + k) % N;
        if (req[idx]) begin
          winner = W'(idx);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_param_arbiter.sv
// rtl/ahb_param_arbiter.sv - parametrised AHB arbiter with burst and lock protection
module ahb_param_arbiter
  import ahb_param_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int NUM_MASTER_BITS = 2,
  parameter int ARB_MODE        = 1,
  parameter int DEFAULT_MASTER  = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic [NUM_MASTERS-1:0]     HBUSREQ,
  input  logic [NUM_MASTERS-1:0]     HLOCK,
  input  logic                       HREADY,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HBURST,
  output logic [NUM_MASTERS-1:0]     HGRANT,
  output logic [NUM_MASTER_BITS-1:0] HMASTER,
  output logic                       HMASTLOCK
);

  localparam logic [NUM_MASTER_BITS-1:0] DEF_IDX = NUM_MASTER_BITS'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]     ONE     = NUM_MASTERS'(1);

  logic [NUM_MASTER_BITS-1:0] grant_idx;
  logic [NUM_MASTER_BITS-1:0] rr_ptr;
  logic [NUM_MASTER_BITS-1:0] pick_idx;
  logic [NUM_MASTER_BITS-1:0] grant_next;
  logic                       pick_valid;
  logic [3:0]                 beats;
  logic [3:0]                 beats_next;
  logic                       arb_ok;

  ahb_rr_pick #(
    .N (NUM_MASTERS),
    .W (NUM_MASTER_BITS)
  ) u_pick (
    .req    (HBUSREQ),
    .base   (rr_ptr),
    .mode   (ARB_MODE != 0),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    beats_next = beats;
    if (HREADY) begin
      case (htrans_e'(HTRANS))
        HTRANS_NONSEQ: beats_next = burst_beats(hburst_e'(HBURST));
        HTRANS_SEQ:    beats_next = (beats != 4'd0) ? beats - 4'd1 : 4'd0;
        HTRANS_IDLE:   beats_next = 4'd0;
        default:       beats_next = beats;
      endcase
    end
  end

  // A locked owner keeps the bus; otherwise the grant may move once no fixed beats remain.
  assign arb_ok     = HREADY && (beats_next == 4'd0) && !HLOCK[grant_idx];
  assign grant_next = pick_valid ? pick_idx : DEF_IDX;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_idx <= DEF_IDX;
      rr_ptr    <= DEF_IDX;
      HGRANT    <= ONE << DEF_IDX;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      beats     <= 4'd0;
    end else begin
      if (arb_ok) begin
        grant_idx <= grant_next;
        rr_ptr    <= grant_next;
        HGRANT    <= ONE << grant_next;
      end
      if (HREADY) begin
        HMASTER   <= grant_idx;
        HMASTLOCK <= HLOCK[grant_idx];
        beats     <= beats_next;
      end
    end
  end

endmodule
